hyper_burst_arbiter: RTL and testbench
======================================

Name: hyper_burst_arbiter

Overview:
- N-master to 1-slave request/grant arbiter for the uDMA HyperBus command/data path. It is the next generation of the binary-tree round-robin arbiter.
- Adds burst locking: the winner keeps the grant until its last beat.
- Adds a runtime-selectable round-robin or fixed-priority mode.
- Adds a MAX_BURST cap that forces re-arbitration.
- Adds proper modulo-N pointer wrap for non-power-of-2 master counts.

Parameters:
- DATA_WIDTH, 32, width of each master's payload.
- N_MASTER, 4, number of requesting masters (>=1, any integer).
- LOG_MASTER, (N_MASTER==1)?1:$clog2(N_MASTER), width of id/pointer.
- MAX_BURST, 16, maximum beats per grant before forced release (>=1).
- CNT_WIDTH, $clog2(MAX_BURST+1), beat counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mode_i  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- req_i  in  N_MASTER  per-master request.
- last_i  in  N_MASTER  per-master "this beat ends the burst".
- data_i  in  N_MASTER x DATA_WIDTH  per-master payload.
- gnt_o  out  N_MASTER  per-master grant (one-hot or zero).
- req_o  out  1  request to slave.
- gnt_i  in  1  grant from slave.
- data_o  out  DATA_WIDTH  selected payload.
- last_o  out  1  burst end toward slave (real or forced).
- id_o  out  LOG_MASTER  index of selected master.
- busy_o  out  1  registered; 1 while a burst is locked.

Behaviour:
- Registered state:
  - state (IDLE/LOCKED)
  - rr_ptr (LOG_MASTER)
  - owner (LOG_MASTER)
  - beat_cnt (CNT_WIDTH)
- Reset values: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0. Resulting outputs with req_i=0: req_o=0, gnt_o=0, last_o=0, id_o=0, busy_o=0, data_o=data_i[0].
- Outputs are combinational from registered state plus inputs. Zero-cycle latency from req_i to req_o.
- A beat completes when req_o && gnt_i.
- IDLE state:
  - sel is chosen among asserted req_i.
  - mode_i=1: lowest asserted index.
  - mode_i=0: first asserted index searching rr_ptr, rr_ptr+1, ..., wrapping N_MASTER-1 -> 0 (modulo N_MASTER, not 2^LOG_MASTER).
  - req_o = |req_i; id_o = sel; data_o = data_i[sel]; gnt_o[sel] = gnt_i, all other bits 0.
- LOCKED state:
  - sel = owner.
  - req_o = req_i[owner]; gnt_o[owner] = gnt_i; all other masters are masked even if requesting.
  - mode_i is ignored.
- last_o = req_o && (last_i[sel] || beat_cnt == MAX_BURST-1).
- On a beat in IDLE with last_o=0: state goes to LOCKED, owner=sel, beat_cnt=1.
- On a beat with last_o=1 (either state): state goes to IDLE, beat_cnt=0, rr_ptr=(sel==N_MASTER-1)?0:sel+1.
  - rr_ptr also updates in fixed mode, so switching back to RR stays fair.
- On a beat in LOCKED with last_o=0: beat_cnt increments.
- MAX_BURST=1: every beat is last; LOCKED is never entered.
- Owner drops req_i mid-burst: req_o=0, lock is held, no timeout. The owner must resume.
- gnt_i=0 holds all state. gnt_i while req_o=0 is ignored.
- A request arriving in the same cycle as a last beat is arbitrated the next cycle against the updated rr_ptr.
- N_MASTER=1: pass-through (req_o=req_i[0], gnt_o[0]=gnt_i, id_o=0). The lock/counter logic still drives last_o and busy_o.
- Reset asserted mid-burst: immediately returns to reset values, and the partial burst is abandoned.
- busy_o = (state==LOCKED).
- No combinational path from gnt_i to req_o.

Test Plan:
- Reset with req_i=4'b1111, mode_i=0, N_MASTER=4, gnt_i=1, last_i=4'b1111 -> id_o sequence 0,1,2,3,0; one gnt_o bit per cycle; busy_o=0 throughout.
- Burst lock: master 2 requests with last_i[2]=0 for 3 beats then 1, while master 0 also requests -> id_o=2 for 4 consecutive beats; gnt_o[0]=0; busy_o=1 on cycles 2-4; then id_o=0.
- Forced release: MAX_BURST=4, master 1 never asserts last -> last_o=1 on beat 4; next winner is master 2 if it requests, else master 1 is re-granted with beat_cnt restarting at 0.
- Fixed priority: mode_i=1, req_i=4'b1010, repeated single beats -> id_o stays 1 every cycle. Switching to mode_i=0 then yields 3,1,3.
- Non-power-of-2: N_MASTER=3, all requesting single beats -> id_o 0,1,2,0 (never 3). A stalled gnt_i=0 for 5 cycles holds id_o and rr_ptr.
- Mid-burst reset: assert rst_n=0 during LOCKED beat 2 -> busy_o=0 and gnt_o=0 asynchronously; after release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/hyper_burst_arbiter.sv
// ---------------------------------------------------------------------------
// hyper_burst_arbiter
//
// N-master to 1-slave request/grant arbiter for the uDMA HyperBus
// command/data path. A winning master keeps the grant until the beat that
// carries its last flag. A burst is cut short after MAX_BURST beats, which
// forces re-arbitration. The arbitration mode is selected at runtime:
// round-robin, or fixed priority where the lowest index wins.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   mode_i   in   0 = round-robin, 1 = fixed priority (lowest index wins)
//   req_i    in   [N_MASTER] per-master request
//   last_i   in   [N_MASTER] per-master "this beat ends the burst"
//   data_i   in   [N_MASTER][DATA_WIDTH] per-master payload
//   gnt_o    out  [N_MASTER] per-master grant (one-hot or zero)
//   req_o    out  request to slave
//   gnt_i    in   grant from slave
//   data_o   out  [DATA_WIDTH] payload of the selected master
//   last_o   out  burst end toward slave (real or forced by the beat cap)
//   id_o     out  [LOG_MASTER] index of the selected master
//   busy_o   out  high while a burst is locked
// ---------------------------------------------------------------------------
module hyper_burst_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int N_MASTER   = 4,
  parameter int LOG_MASTER = (N_MASTER == 1) ? 1 : $clog2(N_MASTER),
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                mode_i,
  input  logic [N_MASTER-1:0]                 req_i,
  input  logic [N_MASTER-1:0]                 last_i,
  input  logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_i,
  output logic [N_MASTER-1:0]                 gnt_o,
  output logic                                req_o,
  input  logic                                gnt_i,
  output logic [DATA_WIDTH-1:0]               data_o,
  output logic                                last_o,
  output logic [LOG_MASTER-1:0]               id_o,
  output logic                                busy_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [LOG_MASTER-1:0] LAST_IDX  = LOG_MASTER'(N_MASTER - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_FORCE = CNT_WIDTH'(MAX_BURST - 1);

  logic [0:0]            r_state;
  logic [LOG_MASTER-1:0] r_rr_ptr;
  logic [LOG_MASTER-1:0] r_owner;
  logic [CNT_WIDTH-1:0]  r_beat_cnt;

  logic [LOG_MASTER-1:0] w_fp_sel;
  logic [LOG_MASTER-1:0] w_rr_sel;
  logic [LOG_MASTER-1:0] w_sel;
  logic [LOG_MASTER-1:0] w_rr_next;
  logic                  w_locked;
  logic                  w_beat;

  // Fixed priority: scan from the top down so the lowest index is written last.
  always_comb begin
    w_fp_sel = '0;
    for (int k = N_MASTER - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        w_fp_sel = LOG_MASTER'(k);
      end
    end
  end

  // Round-robin: search rr_ptr, rr_ptr+1, ... and wrap modulo N_MASTER, so a
  // non-power-of-2 master count never produces an out-of-range index.
  always_comb begin
    int                    idx;
    logic [LOG_MASTER-1:0] w_idx;
    logic                  w_found;
    idx      = 0;
    w_idx    = '0;
    w_found  = 1'b0;
    w_rr_sel = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= N_MASTER) begin
        idx = idx - N_MASTER;
      end
      w_idx = LOG_MASTER'(idx);
      if (!w_found && req_i[w_idx]) begin
        w_found  = 1'b1;
        w_rr_sel = w_idx;
      end
    end
  end

  assign w_locked = (r_state == ST_LOCKED);
  assign w_sel    = w_locked ? r_owner : (mode_i ? w_fp_sel : w_rr_sel);

  // While locked, only the owner's request reaches the slave. Other masters
  // stay masked even if they request.
  assign req_o  = w_locked ? req_i[r_owner] : (|req_i);
  assign id_o   = w_sel;
  assign data_o = data_i[w_sel];
  assign last_o = req_o && (last_i[w_sel] || (r_beat_cnt == CNT_FORCE));
  assign busy_o = w_locked;

  // A grant with no request is ignored, so gnt_o stays zero in that case.
  assign w_beat = req_o && gnt_i;

  genvar gi;
  generate
    for (gi = 0; gi < N_MASTER; gi++) begin : g_gnt
      assign gnt_o[gi] = w_beat && (w_sel == LOG_MASTER'(gi));
    end
  endgenerate

  assign w_rr_next = (w_sel == LAST_IDX) ? '0 : (w_sel + LOG_MASTER'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else if (w_beat) begin
      if (last_o) begin
        // The pointer also advances in fixed mode, so round-robin stays fair
        // after a mode switch.
        r_state    <= ST_IDLE;
        r_beat_cnt <= '0;
        r_rr_ptr   <= w_rr_next;
      end else if (!w_locked) begin
        r_state    <= ST_LOCKED;
        r_owner    <= w_sel;
        r_beat_cnt <= CNT_WIDTH'(1);
      end else begin
        r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_hyper_burst_arbiter.sv
module tb_hyper_burst_arbiter;

  typedef struct {
    int   id;
    logic last;
    logic busy;
  } exp_t;

  logic clk;
  logic rst_n;

  // 4-master instance with a beat cap of 4
  logic              mode4;
  logic [3:0]        req4;
  logic [3:0]        last4;
  logic [3:0][31:0]  data4;
  logic [3:0]        gnt4_o;
  logic              req4_o;
  logic              gnt4_i;
  logic [31:0]       data4_o;
  logic              last4_o;
  logic [1:0]        id4_o;
  logic              busy4_o;

  // 3-master instance (non-power-of-2), default beat cap
  logic              mode3;
  logic [2:0]        req3;
  logic [2:0]        last3;
  logic [2:0][31:0]  data3;
  logic [2:0]        gnt3_o;
  logic              req3_o;
  logic              gnt3_i;
  logic [31:0]       data3_o;
  logic              last3_o;
  logic [1:0]        id3_o;
  logic              busy3_o;

  int   total;
  int   bad;
  exp_t q4[$];
  exp_t q3[$];
  exp_t e4;
  exp_t e3;

  hyper_burst_arbiter #(
    .DATA_WIDTH(32), .N_MASTER(4), .MAX_BURST(4)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode4), .req_i(req4), .last_i(last4),
    .data_i(data4), .gnt_o(gnt4_o), .req_o(req4_o), .gnt_i(gnt4_i),
    .data_o(data4_o), .last_o(last4_o), .id_o(id4_o), .busy_o(busy4_o)
  );

  hyper_burst_arbiter #(
    .DATA_WIDTH(32), .N_MASTER(3)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode3), .req_i(req3), .last_i(last3),
    .data_i(data3), .gnt_o(gnt3_o), .req_o(req3_o), .gnt_i(gnt3_i),
    .data_o(data3_o), .last_o(last3_o), .id_o(id3_o), .busy_o(busy3_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumers: every completed beat pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && req4_o && gnt4_i) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL beat4_unexpected: got id=%0d, required no beat", id4_o);
      end else begin
        e4 = q4.pop_front();
        if (id4_o !== 2'(e4.id) || gnt4_o !== 4'(1 << e4.id) ||
            last4_o !== e4.last || busy4_o !== e4.busy ||
            data4_o !== data4[e4.id]) begin
          bad++;
          $display("FAIL beat4: got id=%0d gnt=%b last=%b busy=%b data=%h, required id=%0d last=%b busy=%b data=%h",
                   id4_o, gnt4_o, last4_o, busy4_o, data4_o, e4.id, e4.last, e4.busy, data4[e4.id]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && req3_o && gnt3_i) begin
      total++;
      if (q3.size() == 0) begin
        bad++;
        $display("FAIL beat3_unexpected: got id=%0d, required no beat", id3_o);
      end else begin
        e3 = q3.pop_front();
        if (id3_o !== 2'(e3.id) || gnt3_o !== 3'(1 << e3.id) ||
            last3_o !== e3.last || busy3_o !== e3.busy ||
            data3_o !== data3[e3.id]) begin
          bad++;
          $display("FAIL beat3: got id=%0d gnt=%b last=%b busy=%b, required id=%0d last=%b busy=%b",
                   id3_o, gnt3_o, last3_o, busy3_o, e3.id, e3.last, e3.busy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input int id, input logic last, input logic busy);
    exp_t e;
    e.id = id; e.last = last; e.busy = busy;
    q4.push_back(e);
  endtask

  task automatic push3(input int id);
    exp_t e;
    e.id = id; e.last = 1'b1; e.busy = 1'b0;
    q3.push_back(e);
  endtask

  task automatic idle4();
    req4 = 4'b0000; last4 = 4'b0000; mode4 = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    total++;
    if (req4_o !== 1'b0 || gnt4_o !== 4'b0 || last4_o !== 1'b0 || id4_o !== 2'd0 ||
        busy4_o !== 1'b0 || data4_o !== data4[0]) begin
      bad++;
      $display("FAIL reset4: got req=%b gnt=%b last=%b id=%0d busy=%b data=%h, required 0 0 0 0 0 %h",
               req4_o, gnt4_o, last4_o, id4_o, busy4_o, data4_o, data4[0]);
    end
    total++;
    if (req3_o !== 1'b0 || gnt3_o !== 3'b0 || id3_o !== 2'd0 || busy3_o !== 1'b0 ||
        data3_o !== data3[0]) begin
      bad++;
      $display("FAIL reset3: got req=%b gnt=%b id=%0d busy=%b data=%h, required 0 0 0 0 %h",
               req3_o, gnt3_o, id3_o, busy3_o, data3_o, data3[0]);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_round_robin();
    mode4 = 1'b0; req4 = 4'b1111; last4 = 4'b1111; gnt4_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      push4(c % 4, 1'b1, 1'b0);
      @(negedge clk);
      step();
    end
    idle4();
  endtask

  // rr_ptr is 1 here, so master 2 beats master 0.
  task automatic test_burst_lock();
    mode4 = 1'b0; req4 = 4'b0101; gnt4_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      last4 = (c == 3) ? 4'b0101 : 4'b0001;
      push4(2, (c == 3), (c != 0));
      @(negedge clk);
      total++;
      if (gnt4_o[0] !== 1'b0) begin
        bad++;
        $display("FAIL lock_mask0 beat %0d: got gnt0=%b, required 0", c, gnt4_o[0]);
      end
      step();
    end
    last4 = 4'b0101;
    push4(0, 1'b1, 1'b0);
    @(negedge clk);
    step();
    idle4();
  endtask

  // Master 1 never asserts last; the cap of 4 beats forces the release.
  task automatic test_forced_release();
    mode4 = 1'b0; gnt4_i = 1'b1;
    req4 = 4'b0110; last4 = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      push4(1, (c == 3), (c != 0));
      @(negedge clk);
      if (c != 0) begin
        total++;
        if (gnt4_o[2] !== 1'b0 || req4_o !== 1'b1) begin
          bad++;
          $display("FAIL forced_mask2 beat %0d: got gnt2=%b req=%b, required 0 1", c, gnt4_o[2], req4_o);
        end
      end
      step();
    end
    last4 = 4'b0100;
    push4(2, 1'b1, 1'b0);
    @(negedge clk);
    step();
    req4 = 4'b0010; last4 = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      push4(1, (c == 3), (c != 0));
      @(negedge clk);
      step();
    end
    idle4();
  endtask

  task automatic test_fixed_priority();
    req4 = 4'b1010; last4 = 4'b1111; gnt4_i = 1'b1; mode4 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      push4(1, 1'b1, 1'b0);
      @(negedge clk);
      step();
    end
    mode4 = 1'b0;
    push4(3, 1'b1, 1'b0);
    @(negedge clk);
    step();
    push4(1, 1'b1, 1'b0);
    @(negedge clk);
    step();
    push4(3, 1'b1, 1'b0);
    @(negedge clk);
    step();
    idle4();
  endtask

  // The owner drops its request mid-burst; the lock is kept and others are masked.
  task automatic test_owner_drop();
    mode4 = 1'b0; gnt4_i = 1'b1; req4 = 4'b0001; last4 = 4'b0000;
    push4(0, 1'b0, 1'b0);
    @(negedge clk);
    step();
    req4 = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (req4_o !== 1'b0 || gnt4_o !== 4'b0 || busy4_o !== 1'b1 || id4_o !== 2'd0) begin
        bad++;
        $display("FAIL owner_drop: got req=%b gnt=%b busy=%b id=%0d, required 0 0000 1 0",
                 req4_o, gnt4_o, busy4_o, id4_o);
      end
      step();
    end
    req4 = 4'b0001; last4 = 4'b0001;
    push4(0, 1'b1, 1'b1);
    @(negedge clk);
    step();
    idle4();
  endtask

  task automatic test_mid_reset();
    mode4 = 1'b0; gnt4_i = 1'b1; req4 = 4'b0010; last4 = 4'b0000;
    push4(1, 1'b0, 1'b0);
    @(negedge clk);
    step();
    push4(1, 1'b0, 1'b1);
    @(negedge clk);
    step();
    total++;
    if (busy4_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_pre: got busy=%b, required 1", busy4_o);
    end
    rst_n = 1'b0;
    req4 = 4'b0000;
    #1;
    total++;
    if (busy4_o !== 1'b0 || gnt4_o !== 4'b0 || req4_o !== 1'b0 || id4_o !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset_async: got busy=%b gnt=%b req=%b id=%0d, required 0 0000 0 0",
               busy4_o, gnt4_o, req4_o, id4_o);
    end
    step();
    rst_n = 1'b1;
    step();
    req4 = 4'b1111; last4 = 4'b1111;
    push4(0, 1'b1, 1'b0);
    @(negedge clk);
    step();
    push4(1, 1'b1, 1'b0);
    @(negedge clk);
    step();
    idle4();
  endtask

  task automatic test_non_pow2();
    mode3 = 1'b0; req3 = 3'b111; last3 = 3'b111; gnt3_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      push3(c % 3);
      @(negedge clk);
      step();
    end
    gnt3_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (id3_o !== 2'd1 || gnt3_o !== 3'b000 || busy3_o !== 1'b0) begin
        bad++;
        $display("FAIL stall3 cycle %0d: got id=%0d gnt=%b busy=%b, required 1 000 0",
                 c, id3_o, gnt3_o, busy3_o);
      end
      step();
    end
    gnt3_i = 1'b1;
    push3(1);
    @(negedge clk);
    step();
    push3(2);
    @(negedge clk);
    step();
    req3 = 3'b000;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    mode4 = 1'b0; req4 = '0; last4 = '0; gnt4_i = 1'b1;
    mode3 = 1'b0; req3 = '0; last3 = '0; gnt3_i = 1'b1;
    for (int i = 0; i < 4; i++) data4[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 3; i++) data3[i] = 32'hB000_0000 + 32'(i);

    test_reset();
    test_round_robin();
    test_burst_lock();
    test_forced_release();
    test_fixed_priority();
    test_owner_drop();
    test_mid_reset();
    test_non_pow2();

    total++;
    if (q4.size() != 0 || q3.size() != 0) begin
      bad++;
      $display("FAIL pending_beats: got q4=%0d q3=%0d outstanding, required 0 0", q4.size(), q3.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
